// File: rtl/ltl_report_collector.sv
// ---------------------------------------------------------------------------
// ltl_report_collector
//
// Collects report pulses from one LTL monitor automaton cluster. Reports are
// valid only in the cycle after a symbol was consumed. Each report becomes an
// event tagged with the index of the symbol that caused it. Events are queued
// in a small first-word-fall-through FIFO and handed to the trace/interrupt
// unit over a valid/ready interface. Events that arrive while the FIFO is full
// are dropped and counted.
//
// Ports
//   clk            clock
//   reset          synchronous, active-high reset
//   run            symbol-consume strobe, the same one the automaton sees
//   reports        automaton report lines (registered inside the automaton)
//   out_valid      head entry available
//   out_ready      consumer accepts the head entry when out_valid=1
//   out_reports    report vector of the head entry (0 when empty)
//   out_index      symbol index of the head entry (0 when empty)
//   out_count      current FIFO occupancy
//   overflow       sticky flag: at least one event was dropped
//   dropped_count  number of dropped events, saturating at 255
//   clear_overflow clears overflow and dropped_count
// ---------------------------------------------------------------------------
module ltl_report_collector #(
    parameter int NUM_REPORTS = 4,
    parameter int IDX_W       = 16,
    parameter int DEPTH       = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     run,
    input  logic [NUM_REPORTS-1:0]   reports,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [NUM_REPORTS-1:0]   out_reports,
    output logic [IDX_W-1:0]         out_index,
    output logic [$clog2(DEPTH):0]   out_count,
    output logic                     overflow,
    output logic [7:0]               dropped_count,
    input  logic                     clear_overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    // symbol tracking
    logic [IDX_W-1:0]       r_idx_cnt;
    logic [IDX_W-1:0]       r_sym_idx_q;
    logic                   r_run_q;

    // FIFO storage and pointers
    logic [NUM_REPORTS-1:0] r_mem_rep [DEPTH];
    logic [IDX_W-1:0]       r_mem_idx [DEPTH];
    logic [AW-1:0]          r_wr_ptr;
    logic [AW-1:0]          r_rd_ptr;
    logic [CW-1:0]          r_count;

    // drop accounting
    logic                   r_overflow;
    logic [7:0]             r_dropped;

    logic                   w_event;
    logic                   w_empty;
    logic                   w_full;
    logic                   w_pop;
    logic                   w_push;
    logic                   w_drop;

    // ------------------------------------------------------------------
    // Symbol counter. sym_idx_q holds the index of the symbol consumed on
    // the previous edge, which is the symbol the current reports refer to.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_idx_cnt   <= '0;
            r_sym_idx_q <= '0;
            r_run_q     <= 1'b0;
        end else begin
            r_run_q <= run;
            if (run) begin
                r_idx_cnt   <= r_idx_cnt + IDX_W'(1);
                r_sym_idx_q <= r_idx_cnt;
            end
        end
    end

    // ------------------------------------------------------------------
    // Event qualification and FIFO handshake
    // ------------------------------------------------------------------
    assign w_event = r_run_q && (|reports);
    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == FULL_CNT);
    assign w_pop   = !w_empty && out_ready;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign w_push  = w_event && (!w_full || w_pop);
    assign w_drop  = w_event && w_full && !w_pop;

    // Storage is not reset; out_* are masked while empty instead.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_rep[r_wr_ptr] <= reports;
            r_mem_idx[r_wr_ptr] <= r_sym_idx_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + CW'(1);
            end else if (w_pop && !w_push) begin
                r_count <= r_count - CW'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // Overflow tracking. A drop in the same cycle as a clear wins, so the
    // dropped event is never lost from the count.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_overflow <= 1'b0;
            r_dropped  <= '0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
            if (clear_overflow) begin
                r_dropped <= 8'd1;
            end else if (r_dropped != 8'hFF) begin
                r_dropped <= r_dropped + 8'd1;
            end
        end else if (clear_overflow) begin
            r_overflow <= 1'b0;
            r_dropped  <= '0;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign out_valid     = !w_empty;
    assign out_reports   = w_empty ? '0 : r_mem_rep[r_rd_ptr];
    assign out_index     = w_empty ? '0 : r_mem_idx[r_rd_ptr];
    assign out_count     = r_count;
    assign overflow      = r_overflow;
    assign dropped_count = r_dropped;

endmodule

// File: doc/ltl_report_collector.md
Name: ltl_report_collector

Overview:
- Sits downstream of one LTL monitor automaton cluster and consumes its report outputs.
- Qualifies report pulses against the symbol stream and tags each report event with the index of the symbol that caused it.
- Queues events in a small FIFO and presents them to the trace/interrupt unit over a valid/ready interface.
- Counts events lost to overflow.

Parameters:
- NUM_REPORTS, 4, number of automaton report lines collected.
- IDX_W, 16, width of the symbol index counter.
- DEPTH, 8, FIFO entries; power of two, ≥2.

Ports:
- clk  input  1  clock.
- reset  input  1  reset, synchronous, active-high.
- run  input  1  same run strobe driven to the automaton; 1 = a symbol is consumed this cycle.
- reports  input  NUM_REPORTS  automaton active-state report lines, registered inside the automaton.
- out_valid  output  1  head entry available.
- out_ready  input  1  consumer accepts head entry when out_valid=1.
- out_reports  output  NUM_REPORTS  report vector of head entry.
- out_index  output  IDX_W  symbol index of head entry.
- out_count  output  $clog2(DEPTH)+1  current FIFO occupancy.
- overflow  output  1  sticky: at least one event dropped.
- dropped_count  output  8  dropped events, saturating at 255.
- clear_overflow  input  1  clears overflow and dropped_count.

Behaviour:
- Reset: FIFO empty. out_valid=0, out_reports=0, out_index=0, out_count=0, overflow=0, dropped_count=0. Symbol counter and run_q cleared. Reset mid-operation discards all queued entries the same edge.
- Symbol counter idx_cnt:
  - On each edge with run=1: idx_cnt<=idx_cnt+1, sym_idx_q<=idx_cnt.
  - run_q<=run every cycle.
  - Wraps from 2^IDX_W-1 to 0 silently.
- Qualification: automaton reports for symbol n are visible the cycle after run. An event is generated when run_q=1 and |reports=1. The entry is {reports, sym_idx_q}. Reports with run_q=0 are ignored.
- FIFO:
  - First-word-fall-through. out_valid=(count!=0).
  - out_reports/out_index show the head entry; both are 0 when empty.
  - Pop when out_valid&&out_ready.
  - Push accepted when count<DEPTH, or when count==DEPTH and a pop occurs in the same cycle.
  - Simultaneous push+pop leaves count unchanged.
  - Read and write pointers are $clog2(DEPTH) bits and wrap naturally.
- Drop: event while count==DEPTH with no pop → entry discarded, overflow<=1, dropped_count<=min(dropped_count+1,255).
- clear_overflow=1:
  - Without a drop in the same cycle: overflow<=0, dropped_count<=0.
  - With a drop in the same cycle: overflow<=1, dropped_count<=1 (drop wins).
- Latency: symbol consumed at edge k → automaton report visible after k → entry pushed at edge k+1 → out_valid high after k+1 if FIFO was empty.
- out_ready with out_valid=0 has no effect.
- Holding out_valid: once high, out_valid and the head data stay stable until popped or reset.

Test Plan:
- Reset, then run=1 for symbols 0..4 with reports=4'b0000 except reports=4'b0010 in the cycle after symbol 3, out_ready=1 → exactly one entry, out_reports=4'b0010, out_index=3, out_valid high for 1 cycle, then out_count=0.
- reports=4'b1111 held while run_q=0 for 5 cycles → no entries; out_valid stays 0, out_count=0.
- out_ready=0 with 10 qualifying events at symbols 0..9 → out_count=8, overflow=1, dropped_count=2. Draining with out_ready=1 yields indices 0..7 in order.
- FIFO full, with a qualifying event and out_ready=1 in the same cycle → pop of index 0 and push accepted, out_count stays 8, overflow unchanged at 0.
- Overflow state dropped_count=2, then clear_overflow=1 with no drop → overflow=0, dropped_count=0. Repeat with a drop in the same cycle → overflow=1, dropped_count=1. Force 300 drops → dropped_count=255.
- IDX_W=4, 20 symbols with a report on symbol 17 → out_index=1 (wrap). Assert reset while 3 entries are queued → next cycle out_valid=0, out_count=0, and the next symbol gets index 0.
